// File: rtl/apb4_plic_claimer.sv
// APB4 initiator that claims PLIC interrupts for one hart context, hands the ID to the core and writes it back on completion.
// Optional ACCESS-phase timeout is built in when APB4_PLIC_CLAIMER_TIMEOUT_EN is defined.
module apb4_plic_claimer #(
  parameter logic [31:0] PLIC_BASE      = 32'h0000_0000,
  parameter logic [31:0] CLAIMCOMP_OFS  = 32'h24,
  parameter int unsigned ID_WIDTH       = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                irq_i,
  output logic [31:0]         paddr,
  output logic [2:0]          pprot,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [31:0]         pwdata,
  output logic [3:0]          pstrb,
  input  logic                pready,
  input  logic [31:0]         prdata,
  input  logic                pslverr,
  output logic                id_valid_o,
  output logic [ID_WIDTH-1:0] id_o,
  input  logic                id_ready_i,
  input  logic                cmpl_valid_i,
  output logic                cmpl_ready_o,
  output logic                busy_o,
  output logic                err_o,
  output logic [7:0]          spur_cnt_o
);

  localparam logic [31:0] CLAIM_ADDR = PLIC_BASE + CLAIMCOMP_OFS;
  localparam int unsigned SPUR_W     = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLM_SETUP  = 3'd1,
    CLM_ACCESS = 3'd2,
    DELIVER    = 3'd3,
    WAIT_CMPL  = 3'd4,
    CMP_SETUP  = 3'd5,
    CMP_ACCESS = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [SPUR_W-1:0]   spur_q, spur_d;
  logic [31:0]         paddr_q, paddr_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic [3:0]          pstrb_q, pstrb_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic                id_valid_q, id_valid_d;
  logic                cmpl_ready_q, cmpl_ready_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                timeout_c;
  logic                in_access_c;
  logic                unused_c;

  assign in_access_c = (state_q == CLM_ACCESS) || (state_q == CMP_ACCESS);
  assign unused_c    = ^{prdata[31:ID_WIDTH], 32'(TIMEOUT_CYCLES)};

`ifdef APB4_PLIC_CLAIMER_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts stalled ACCESS cycles; reads as zero on the first cycle of each ACCESS phase.
  always_comb begin
    to_cnt_d = '0;
    if (in_access_c && !pready) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  assign timeout_c = in_access_c && !pready && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next state plus the registered-output values that the next state implies.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    spur_d       = spur_q;
    paddr_d      = paddr_q;
    err_d        = 1'b0;
    psel_d       = 1'b0;
    penable_d    = 1'b0;
    pwrite_d     = 1'b0;
    pwdata_d     = '0;
    pstrb_d      = 4'h0;
    id_valid_d   = 1'b0;
    cmpl_ready_d = 1'b0;
    busy_d       = 1'b0;

    case (state_q)
      IDLE:       if (irq_i) state_d = CLM_SETUP;
      CLM_SETUP:  state_d = CLM_ACCESS;
      CLM_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            id_d = prdata[ID_WIDTH-1:0];
            if (prdata[ID_WIDTH-1:0] == '0) begin
              if (spur_q != '1) spur_d = spur_q + SPUR_W'(1);
              state_d = IDLE;
            end else begin
              state_d = DELIVER;
            end
          end
        end else if (timeout_c) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DELIVER:    if (id_ready_i) state_d = WAIT_CMPL;
      WAIT_CMPL:  if (cmpl_valid_i) state_d = CMP_SETUP;
      CMP_SETUP:  state_d = CMP_ACCESS;
      CMP_ACCESS: begin
        if (pready) begin
          err_d   = pslverr;
          state_d = IDLE;
        end else if (timeout_c) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default:    state_d = IDLE;
    endcase

    // Address is loaded at each SETUP and then simply held.
    if (state_d == CLM_SETUP || state_d == CMP_SETUP) paddr_d = CLAIM_ADDR;

    psel_d       = state_d inside {CLM_SETUP, CLM_ACCESS, CMP_SETUP, CMP_ACCESS};
    penable_d    = state_d inside {CLM_ACCESS, CMP_ACCESS};
    pwrite_d     = state_d inside {CMP_SETUP, CMP_ACCESS};
    pwdata_d     = pwrite_d ? 32'(id_d) : 32'h0;
    pstrb_d      = pwrite_d ? 4'hF : 4'h0;
    id_valid_d   = (state_d == DELIVER);
    cmpl_ready_d = (state_d == WAIT_CMPL);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= IDLE;
      id_q         <= '0;
      spur_q       <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= 4'h0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      id_valid_q   <= 1'b0;
      cmpl_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      spur_q       <= spur_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      id_valid_q   <= id_valid_d;
      cmpl_ready_q <= cmpl_ready_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign paddr        = paddr_q;
  assign pprot        = 3'b000;
  assign psel         = psel_q;
  assign penable      = penable_q;
  assign pwrite       = pwrite_q;
  assign pwdata       = pwdata_q;
  assign pstrb        = pstrb_q;
  assign id_valid_o   = id_valid_q;
  assign id_o         = id_q;
  assign cmpl_ready_o = cmpl_ready_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
  assign spur_cnt_o   = spur_q;

endmodule

// File: tb/tb_apb4_plic_claimer.sv
// Directed, table-driven bench for apb4_plic_claimer (default build, timeout feature off).
module tb_apb4_plic_claimer;

  localparam logic [31:0] CC_ADDR = 32'h0000_0024;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        irq_i = 1'b0;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'h0;
  logic        pslverr = 1'b0;
  logic        id_valid_o;
  logic [4:0]  id_o;
  logic        id_ready_i = 1'b0;
  logic        cmpl_valid_i = 1'b0;
  logic        cmpl_ready_o, busy_o, err_o;
  logic [7:0]  spur_cnt_o;

  int nchk = 0;
  int nerr = 0;

  apb4_plic_claimer dut (
    .pclk(pclk), .presetn(presetn), .irq_i(irq_i),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .id_valid_o(id_valid_o), .id_o(id_o), .id_ready_i(id_ready_i),
    .cmpl_valid_i(cmpl_valid_i), .cmpl_ready_o(cmpl_ready_o),
    .busy_o(busy_o), .err_o(err_o), .spur_cnt_o(spur_cnt_o)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rdata;
    logic        clm_err;
    int unsigned wait_cyc;
    logic        cmp_err;
    logic        exp_valid;
    logic [4:0]  exp_id;
    logic [7:0]  exp_spur;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One complete claim (and completion, if an ID is delivered); irq_i held high until IDLE.
  task automatic run_claim(input vec_t v);
    irq_i   = 1'b1;
    prdata  = v.rdata;
    pslverr = 1'b0;
    pready  = 1'b0;
    tick();
    chk("clm_setup_ctl", 32'({psel, penable, pwrite}), 32'b100);
    chk("clm_setup_addr", paddr, CC_ADDR);
    chk("clm_setup_strb", 32'(pstrb), 32'h0);
    tick();
    chk("clm_access_ctl", 32'({psel, penable, pwrite}), 32'b110);
    for (int i = 0; i < int'(v.wait_cyc); i++) begin
      tick();
      chk("clm_wait_ctl", 32'({psel, penable, pwrite}), 32'b110);
      chk("clm_wait_addr", paddr, CC_ADDR);
      chk("clm_wait_novalid", 32'(id_valid_o), 32'd0);
    end
    pready  = 1'b1;
    pslverr = v.clm_err;
    tick();
    pready  = 1'b0;
    pslverr = 1'b0;
    chk("clm_id_valid", 32'(id_valid_o), 32'(v.exp_valid));
    chk("clm_spur", 32'(spur_cnt_o), 32'(v.exp_spur));
    chk("clm_err", 32'(err_o), 32'(v.clm_err));
    chk("clm_psel_off", 32'({psel, penable}), 32'd0);
    if (v.exp_valid) begin
      chk("deliver_id", 32'(id_o), 32'(v.exp_id));
      cmpl_valid_i = 1'b1;
      tick();
      chk("deliver_hold", 32'({id_valid_o, cmpl_ready_o}), 32'b10);
      chk("deliver_id_stable", 32'(id_o), 32'(v.exp_id));
      cmpl_valid_i = 1'b0;
      id_ready_i   = 1'b1;
      tick();
      id_ready_i = 1'b0;
      chk("wait_cmpl", 32'({id_valid_o, cmpl_ready_o, psel}), 32'b010);
      cmpl_valid_i = 1'b1;
      tick();
      cmpl_valid_i = 1'b0;
      chk("cmp_setup_ctl", 32'({psel, penable, pwrite, cmpl_ready_o}), 32'b1010);
      chk("cmp_setup_wdata", pwdata, 32'(v.exp_id));
      chk("cmp_setup_strb", 32'(pstrb), 32'hF);
      chk("cmp_setup_addr", paddr, CC_ADDR);
      pready  = 1'b1;
      pslverr = v.cmp_err;
      tick();
      chk("cmp_access_ctl", 32'({psel, penable, pwrite}), 32'b111);
      chk("cmp_access_wdata", pwdata, 32'(v.exp_id));
      tick();
      pready  = 1'b0;
      pslverr = 1'b0;
      irq_i   = 1'b0;
      chk("cmp_idle", 32'({busy_o, psel, penable}), 32'd0);
      chk("cmp_err", 32'(err_o), 32'(v.cmp_err));
      tick();
      chk("cmp_err_pulse_end", 32'(err_o), 32'd0);
    end else begin
      irq_i = 1'b0;
      chk("noclaim_idle", 32'(busy_o), 32'd0);
      tick();
      chk("noclaim_quiet", 32'({err_o, id_valid_o, busy_o}), 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{32'h0000_0005, 1'b0, 0, 1'b0, 1'b1, 5'd5,  8'd0};
    vecs[1] = '{32'h0000_0000, 1'b0, 0, 1'b0, 1'b0, 5'd0,  8'd1};
    vecs[2] = '{32'h0000_0013, 1'b0, 4, 1'b0, 1'b1, 5'h13, 8'd1};
    vecs[3] = '{32'h0000_0007, 1'b1, 0, 1'b0, 1'b0, 5'd0,  8'd1};
    vecs[4] = '{32'hFFFF_FFE0, 1'b0, 0, 1'b0, 1'b0, 5'd0,  8'd2};
    vecs[5] = '{32'hABCD_EF1F, 1'b0, 0, 1'b1, 1'b1, 5'h1F, 8'd2};
    vecs[6] = '{32'h0000_0003, 1'b0, 1, 1'b0, 1'b1, 5'd3,  8'd2};
    vecs[7] = '{32'h0000_0000, 1'b0, 2, 1'b0, 1'b0, 5'd0,  8'd3};

    // Reset values
    #2;
    chk("rst_outputs", 32'({psel, penable, pwrite, id_valid_o, cmpl_ready_o, busy_o, err_o}), 32'd0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_misc", 32'({pprot, pstrb, id_o, spur_cnt_o}), 32'd0);
    chk("rst_pwdata", pwdata, 32'h0);
    @(negedge pclk);
    presetn = 1'b1;
    tick();
    chk("idle_after_rst", 32'(busy_o), 32'd0);

    foreach (vecs[k]) run_claim(vecs[k]);

    // Spurious-claim counter saturation
    for (int k = 0; k < 300; k++) begin
      v = '{32'h0, 1'b0, 0, 1'b0, 1'b0, 5'd0, ((k + 4) > 255) ? 8'd255 : 8'(k + 4)};
      run_claim(v);
    end
    chk("spur_saturated", 32'(spur_cnt_o), 32'd255);

    // No timeout in this build: stuck pready keeps the claim in ACCESS
    irq_i = 1'b1;
    tick();
    irq_i = 1'b0;
    tick();
    for (int i = 0; i < 1000; i++) @(posedge pclk);
    #1;
    chk("stuck_access_ctl", 32'({psel, penable, busy_o, err_o}), 32'b1110);
    chk("stuck_access_addr", paddr, CC_ADDR);
    prdata = 32'h0;
    pready = 1'b1;
    tick();
    pready = 1'b0;
    chk("stuck_release_idle", 32'({busy_o, err_o}), 32'd0);
    chk("stuck_spur_sat", 32'(spur_cnt_o), 32'd255);
    tick();

    // Reset asserted during CMP_ACCESS, then an immediate new claim
    irq_i  = 1'b1;
    prdata = 32'h0000_0009;
    pready = 1'b1;
    tick();
    tick();
    tick();
    chk("rs_deliver", 32'({id_valid_o, id_o}), 32'({1'b1, 5'd9}));
    id_ready_i = 1'b1;
    tick();
    id_ready_i   = 1'b0;
    cmpl_valid_i = 1'b1;
    tick();
    cmpl_valid_i = 1'b0;
    pready       = 1'b0;
    tick();
    chk("rs_in_cmp_access", 32'({psel, penable, pwrite}), 32'b111);
    #1 presetn = 1'b0;
    #1;
    chk("rs_async_clear", 32'({psel, penable, busy_o, pwrite, cmpl_ready_o}), 32'd0);
    chk("rs_spur_clear", 32'(spur_cnt_o), 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    tick();
    chk("rs_new_claim_setup", 32'({psel, penable, pwrite}), 32'b100);
    chk("rs_new_claim_addr", paddr, CC_ADDR);
    prdata = 32'h0;
    pready = 1'b1;
    tick();
    irq_i = 1'b0;
    tick();
    pready = 1'b0;
    chk("rs_spurious_after", 32'({busy_o, spur_cnt_o}), 32'({1'b0, 8'd1}));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
